// File: rtl/multdiv_scoreboard.sv
// Tracks mul/div ops through the multdiv pipeline: per-stage occupancy, D/X
// bypass requests, in-flight count and the retire pulse toward writeback.
module multdiv_scoreboard #(
    parameter int unsigned DEPTH = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic             issue_div,
    input  logic [4:0]       issue_rd,
    input  logic             issue_dz,
    input  logic [4:0]       dx_rs,
    input  logic [4:0]       dx_rt,
    input  logic [4:0]       dx_rd,
    input  logic             dx_reads_rs,
    input  logic             dx_reads_rt,
    input  logic             dx_reads_rd,
    input  logic             wb_stall,
    output logic             issue_ready,
    output logic [DEPTH-1:0] busy_stage,
    output logic [DEPTH-1:0] bp_reqX,
    output logic             exc_piped,
    output logic             done_valid,
    output logic [4:0]       done_rd,
    output logic             done_exc,
    output logic [4:0]       inflight
);

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 5;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          is_div;
        logic          dz;
    } slot_t;

    slot_t         slot_q [DEPTH];
    slot_t         slot_d [DEPTH];
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;

    logic freeze_c;
    logic issue_acc_c;
    logic retire_c;

    // A valid op at the exit stage that cannot write back stalls the whole pipe.
    assign freeze_c    = slot_q[DEPTH-1].valid & wb_stall;
    assign issue_ready = ~freeze_c;
    assign issue_acc_c = issue & ~freeze_c;
    assign retire_c    = slot_q[DEPTH-1].valid & ~wb_stall;

    // Next-state: shift one stage unless frozen, loading the new issue into slot 0.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        inflight_d = inflight_q;
        if (!freeze_c) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0].valid  = issue_acc_c;
            slot_d[0].rd     = issue_acc_c ? issue_rd : '0;
            slot_d[0].is_div = issue_acc_c & issue_div;
            slot_d[0].dz     = issue_acc_c & issue_div & issue_dz;
            inflight_d       = inflight_q + CW'(issue_acc_c) - CW'(retire_c);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            inflight_q <= inflight_d;
        end
    end

    // Occupancy and bypass requests; rd = 0 never needs forwarding.
    always_comb begin
        busy_stage = '0;
        bp_reqX    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_stage[i] = slot_q[i].valid;
            bp_reqX[i]    = slot_q[i].valid && (slot_q[i].rd != '0) &&
                            ((dx_reads_rs && (slot_q[i].rd == dx_rs)) ||
                             (dx_reads_rt && (slot_q[i].rd == dx_rt)) ||
                             (dx_reads_rd && (slot_q[i].rd == dx_rd)));
        end
    end

    assign exc_piped  = |busy_stage;
    assign done_valid = retire_c;
    assign done_rd    = retire_c ? slot_q[DEPTH-1].rd : '0;
    assign done_exc   = retire_c & slot_q[DEPTH-1].is_div & slot_q[DEPTH-1].dz;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against an
// op-list reference model (each op carries its age in stages).
module tb_multdiv_scoreboard;

    localparam int unsigned DEPTH = 17;

    logic             clock = 1'b0;
    logic             reset;
    logic             issue, issue_div, issue_dz;
    logic [4:0]       issue_rd;
    logic [4:0]       dx_rs, dx_rt, dx_rd;
    logic             dx_reads_rs, dx_reads_rt, dx_reads_rd;
    logic             wb_stall;
    logic             issue_ready;
    logic [DEPTH-1:0] busy_stage, bp_reqX;
    logic             exc_piped, done_valid, done_exc;
    logic [4:0]       done_rd, inflight;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] rd;
        logic       is_div;
        logic       dz;
        int         pos;
    } op_t;

    op_t ops[$];

    multdiv_scoreboard #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue       (issue),
        .issue_div   (issue_div),
        .issue_rd    (issue_rd),
        .issue_dz    (issue_dz),
        .dx_rs       (dx_rs),
        .dx_rt       (dx_rt),
        .dx_rd       (dx_rd),
        .dx_reads_rs (dx_reads_rs),
        .dx_reads_rt (dx_reads_rt),
        .dx_reads_rd (dx_reads_rd),
        .wb_stall    (wb_stall),
        .issue_ready (issue_ready),
        .busy_stage  (busy_stage),
        .bp_reqX     (bp_reqX),
        .exc_piped   (exc_piped),
        .done_valid  (done_valid),
        .done_rd     (done_rd),
        .done_exc    (done_exc),
        .inflight    (inflight)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic iss, input logic div, input logic [4:0] rd,
                         input logic dz, input logic stall);
        reset     = rst;
        issue     = iss;
        issue_div = div;
        issue_rd  = rd;
        issue_dz  = dz;
        wb_stall  = stall;
    endtask

    task automatic drive_dx(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic rrs, input logic rrt, input logic rrd);
        dx_rs = rs; dx_rt = rt; dx_rd = rd;
        dx_reads_rs = rrs; dx_reads_rt = rrt; dx_reads_rd = rrd;
    endtask

    function automatic logic model_frozen();
        foreach (ops[k]) if (ops[k].pos == DEPTH - 1 && wb_stall) return 1'b1;
        return 1'b0;
    endfunction

    // Compare every output against what the op list implies for the current inputs.
    task automatic check_outputs();
        logic [DEPTH-1:0] eb, ebp;
        logic             dv, dex;
        logic [4:0]       drd;
        eb = '0; ebp = '0; dv = 1'b0; dex = 1'b0; drd = '0;
        foreach (ops[k]) begin
            eb[ops[k].pos] = 1'b1;
            if (ops[k].rd != 0 &&
                ((dx_reads_rs && ops[k].rd == dx_rs) ||
                 (dx_reads_rt && ops[k].rd == dx_rt) ||
                 (dx_reads_rd && ops[k].rd == dx_rd)))
                ebp[ops[k].pos] = 1'b1;
            if (ops[k].pos == DEPTH - 1 && !wb_stall) begin
                dv  = 1'b1;
                drd = ops[k].rd;
                dex = ops[k].is_div && ops[k].dz;
            end
        end
        check_eq("issue_ready", 32'(issue_ready), 32'(!model_frozen()));
        check_eq("busy_stage",  32'(busy_stage),  32'(eb));
        check_eq("bp_reqX",     32'(bp_reqX),     32'(ebp));
        check_eq("exc_piped",   32'(exc_piped),   32'(ops.size() != 0));
        check_eq("done_valid",  32'(done_valid),  32'(dv));
        check_eq("done_rd",     32'(done_rd),     32'(drd));
        check_eq("done_exc",    32'(done_exc),    32'(dex));
        check_eq("inflight",    32'(inflight),    32'(ops.size()));
    endtask

    task automatic model_update();
        op_t o;
        if (reset) begin
            ops.delete();
        end else if (!model_frozen()) begin
            for (int k = ops.size() - 1; k >= 0; k--)
                if (ops[k].pos == DEPTH - 1) ops.delete(k);
            foreach (ops[k]) ops[k].pos++;
            if (issue) begin
                o.rd = issue_rd; o.is_div = issue_div; o.dz = issue_dz; o.pos = 0;
                ops.push_back(o);
            end
        end
    endtask

    task automatic sample();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            cycle();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive_dx(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        advance();
        cycle();
        check_eq("reset_ready", 32'(issue_ready), 32'd1);
        check_eq("reset_busy",  32'(busy_stage),  32'd0);

        // Single mul walking the whole pipe.
        drive(1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
        cycle();
        idle(16);
        sample();
        check_eq("mul_retire_rd", 32'(done_rd), 32'd5);
        advance();
        idle(2);
        check_eq("mul_drained", 32'(inflight), 32'd0);

        // Divide-by-zero flag only on div.
        drive(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle();
        idle(15);
        sample();
        check_eq("div_dz_exc", 32'(done_exc), 32'd1);
        advance();
        sample();
        check_eq("mul_dz_noexc", 32'(done_exc), 32'd0);
        advance();
        idle(2);

        // Bypass request from P4.
        drive(1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
        cycle();
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive_dx(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("bp_p4", 32'(bp_reqX), 32'h10);
        drive_dx(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check_eq("bp_noread", 32'(bp_reqX), 32'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        idle(4);
        drive_dx(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        sample();
        check_eq("bp_rd0", 32'(bp_reqX), 32'h0);
        check_eq("rd0_busy_p4", 32'(busy_stage), 32'h10);
        advance();
        drive_dx(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(13);

        // Freeze with op at the exit stage while issue is held high.
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
        cycle();
        idle(16);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1);
            sample();
            check_eq("frz_ready", 32'(issue_ready), 32'd0);
            check_eq("frz_busy",  32'(busy_stage),  32'h10000);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("unfrz_retire", 32'(done_valid), 32'd1);
        advance();
        idle(2);

        // Full pipe, then issue and retire coinciding.
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 1'b1, 1'(k & 1), 5'(k), 1'b0, 1'b0);
            cycle();
        end
        check_eq("full_inflight", 32'(inflight), 32'd17);
        check_eq("full_busy", 32'(busy_stage), 32'h1FFFF);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
            cycle();
        end
        check_eq("steady_inflight", 32'(inflight), 32'd17);

        // Reset with ops in flight.
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        idle(3);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 5'(k + 1), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample();
        check_eq("rst_busy", 32'(busy_stage), 32'd0);
        check_eq("rst_inflight", 32'(inflight), 32'd0);
        check_eq("rst_piped", 32'(exc_piped), 32'd0);
        advance();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(1'(($urandom % 100) == 0), 1'(($urandom % 100) < 60), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom), 1'(($urandom % 100) < 30));
            drive_dx(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
